// File: rtl/fd_pipe_if.sv
// Fetch-stage output bundle handed to the F->D pipeline register.
// Fetch drives it through the master modport; the decode register reads it through the slave modport.
interface fd_pipe_if;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [2:0]  f_stat;

    modport master (
        output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat
    );

    modport slave (
        input f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat
    );
endinterface

// File: rtl/fd_pipe_ctrl.sv
// Y86-64 F->D pipeline register with load/use, mispredict and ret hazard control,
// plus saturating stall and bubble event counters.
module fd_pipe_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter logic [3:0]  RNONE = 4'hF,
    parameter logic [3:0]  RRSP  = 4'h4
) (
    input  logic             clk,
    input  logic             rst_n,
    fd_pipe_if.slave         fetch,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    output logic [3:0]       D_icode,
    output logic [3:0]       D_ifun,
    output logic [3:0]       D_rA,
    output logic [3:0]       D_rB,
    output logic [63:0]      D_valC,
    output logic [63:0]      D_valP,
    output logic [2:0]       D_stat,
    output logic [3:0]       d_srcA,
    output logic [3:0]       d_srcB,
    output logic             F_stall,
    output logic             E_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [2:0] S_BUB    = 3'd0;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic load_use;
    logic mispredict;
    logic ret_busy;
    logic D_stall;
    logic D_bubble;

    always_comb begin
        d_srcA = RNONE;
        unique case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
            I_POPQ, I_RET:                      d_srcA = RRSP;
            default:                            d_srcA = RNONE;
        endcase
    end

    always_comb begin
        d_srcB = RNONE;
        unique case (D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:     d_srcB = RRSP;
            default:                            d_srcB = RNONE;
        endcase
    end

    always_comb begin
        load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                     (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispredict = (E_icode == I_JXX) && !e_Cnd;
        ret_busy   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        F_stall    = load_use || ret_busy;
        D_stall    = load_use;
        // Stall wins over bubble: a ret waiting on a load holds D one cycle, then resumes bubbling.
        D_bubble   = mispredict || (ret_busy && !load_use);
        E_bubble   = mispredict || load_use;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_icode <= I_NOP;
            D_ifun  <= '0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= '0;
            D_valP  <= '0;
            D_stat  <= S_BUB;
        end else if (D_stall) begin
            D_icode <= D_icode;
            D_ifun  <= D_ifun;
            D_rA    <= D_rA;
            D_rB    <= D_rB;
            D_valC  <= D_valC;
            D_valP  <= D_valP;
            D_stat  <= D_stat;
        end else if (D_bubble) begin
            D_icode <= I_NOP;
            D_ifun  <= '0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= '0;
            D_valP  <= '0;
            D_stat  <= S_BUB;
        end else begin
            D_icode <= fetch.f_icode;
            D_ifun  <= fetch.f_ifun;
            D_rA    <= fetch.f_rA;
            D_rB    <= fetch.f_rB;
            D_valC  <= fetch.f_valC;
            D_valP  <= fetch.f_valP;
            D_stat  <= fetch.f_stat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (F_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (D_bubble && !D_stall && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fd_pipe_ctrl.sv
// Directed bench for fd_pipe_ctrl: a rule-level reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_fd_pipe_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam logic [3:0]  RNONE = 4'hF;
    localparam logic [3:0]  RRSP  = 4'h4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] E_icode = 4'h1;
    logic [3:0] E_dstM  = 4'hF;
    logic       e_Cnd   = 1'b1;
    logic [3:0] M_icode = 4'h1;

    logic [3:0]       D_icode, D_ifun, D_rA, D_rB, d_srcA, d_srcB;
    logic [63:0]      D_valC, D_valP;
    logic [2:0]       D_stat;
    logic             F_stall, E_bubble;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    fd_pipe_if fif ();

    fd_pipe_ctrl #(.CNT_W(CNT_W), .RNONE(RNONE), .RRSP(RRSP)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fif.slave),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .F_stall(F_stall), .E_bubble(E_bubble),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: the architectural contents of the D register and the counters.
    int m_icode, m_ifun, m_rA, m_rB, m_stat;
    longint unsigned m_valC, m_valP;
    int m_stall, m_bubble;

    function automatic int src_a(int icode, int rA);
        if (icode == 2 || icode == 4 || icode == 6 || icode == 10) return rA;
        if (icode == 11 || icode == 9) return int'(RRSP);
        return int'(RNONE);
    endfunction

    function automatic int src_b(int icode, int rB);
        if (icode == 4 || icode == 5 || icode == 6) return rB;
        if (icode == 10 || icode == 11 || icode == 8 || icode == 9) return int'(RRSP);
        return int'(RNONE);
    endfunction

    function automatic bit m_load_use();
        int sa, sb;
        sa = src_a(m_icode, m_rA);
        sb = src_b(m_icode, m_rB);
        return (E_icode == 5 || E_icode == 11) && (E_dstM != RNONE) &&
               (int'(E_dstM) == sa || int'(E_dstM) == sb);
    endfunction

    function automatic bit m_mispred();
        return (E_icode == 7) && !e_Cnd;
    endfunction

    function automatic bit m_ret();
        return m_icode == 9 || E_icode == 9 || M_icode == 9;
    endfunction

    task automatic m_set_bubble();
        m_icode = 1; m_ifun = 0; m_rA = 15; m_rB = 15;
        m_valC = 0; m_valP = 0; m_stat = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_set_bubble();
            m_stall = 0;
            m_bubble = 0;
        end else begin
            bit lu, bub;
            lu  = m_load_use();
            bub = m_mispred() || m_ret();
            if (lu || m_ret()) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
            if (bub && !lu) m_bubble = (m_bubble == CMAX) ? CMAX : m_bubble + 1;
            if (lu) begin
                // hold
            end else if (bub) begin
                m_set_bubble();
            end else begin
                m_icode = fif.f_icode; m_ifun = fif.f_ifun;
                m_rA = fif.f_rA; m_rB = fif.f_rB;
                m_valC = fif.f_valC; m_valP = fif.f_valP;
                m_stat = fif.f_stat;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed && rst_n) begin
            chk("m_D_icode", 64'(D_icode), 64'(m_icode));
            chk("m_D_ifun",  64'(D_ifun),  64'(m_ifun));
            chk("m_D_rA",    64'(D_rA),    64'(m_rA));
            chk("m_D_rB",    64'(D_rB),    64'(m_rB));
            chk("m_D_valC",  D_valC,       m_valC);
            chk("m_D_valP",  D_valP,       m_valP);
            chk("m_D_stat",  64'(D_stat),  64'(m_stat));
            chk("m_d_srcA",  64'(d_srcA),  64'(src_a(m_icode, m_rA)));
            chk("m_d_srcB",  64'(d_srcB),  64'(src_b(m_icode, m_rB)));
            chk("m_F_stall", 64'(F_stall), 64'(m_load_use() || m_ret()));
            chk("m_E_bubble",64'(E_bubble),64'(m_mispred() || m_load_use()));
            chk("m_stall_cnt",  64'(stall_cnt),  64'(m_stall));
            chk("m_bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
        end
    end

    // Inputs change 2 time units after the rising edge, well clear of both sampling edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_f(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp, input logic [2:0] st);
        fif.f_icode = ic; fif.f_ifun = 4'h0; fif.f_rA = ra; fif.f_rB = rb;
        fif.f_valC = vc; fif.f_valP = vp; fif.f_stat = st;
    endtask

    task automatic stage_idle();
        E_icode = 4'h1; E_dstM = RNONE; e_Cnd = 1'b1; M_icode = 4'h1;
    endtask

    initial begin
        set_f(4'h1, RNONE, RNONE, 64'd0, 64'd0, 3'd1);
        stage_idle();
        #3 rst_n = 1'b0;
        #24;
        @(negedge clk);
        rst_n = 1'b1;
        armed = 1'b1;
        #1;
        chk("rst_D_icode", 64'(D_icode), 64'h1);
        chk("rst_D_rA", 64'(D_rA), 64'hF);
        chk("rst_D_rB", 64'(D_rB), 64'hF);
        chk("rst_D_valC", D_valC, 64'h0);
        chk("rst_D_stat", 64'(D_stat), 64'h0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("rst_F_stall", 64'(F_stall), 64'h0);
        chk("rst_E_bubble", 64'(E_bubble), 64'h0);

        // Passthrough of an irmovq.
        set_f(4'h3, RNONE, 4'h2, 64'd10, 64'd10, 3'd1);
        tick();
        chk("pt_D_icode", 64'(D_icode), 64'h3);
        chk("pt_D_valC", D_valC, 64'd10);
        chk("pt_D_valP", D_valP, 64'd10);
        chk("pt_d_srcA", 64'(d_srcA), 64'hF);
        chk("pt_d_srcB", 64'(d_srcB), 64'hF);
        chk("pt_F_stall", 64'(F_stall), 64'h0);

        // Load/use: OPq rA=1 rB=2 in D, mrmovq to %rdx (2) in E.
        set_f(4'h6, 4'h1, 4'h2, 64'd0, 64'd20, 3'd1);
        tick();
        set_f(4'h3, RNONE, 4'h3, 64'd7, 64'd30, 3'd1);
        E_icode = 4'h5; E_dstM = 4'h2;
        #1;
        chk("lu_F_stall", 64'(F_stall), 64'h1);
        chk("lu_E_bubble", 64'(E_bubble), 64'h1);
        chk("lu_d_srcA", 64'(d_srcA), 64'h1);
        chk("lu_d_srcB", 64'(d_srcB), 64'h2);
        tick();
        chk("lu_D_icode_held", 64'(D_icode), 64'h6);
        chk("lu_D_valP_held", D_valP, 64'd20);
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        stage_idle();
        tick();
        chk("lu_resume_icode", 64'(D_icode), 64'h3);

        // Mispredicted jump in E.
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        chk("mp_E_bubble", 64'(E_bubble), 64'h1);
        chk("mp_F_stall", 64'(F_stall), 64'h0);
        tick();
        chk("mp_D_icode", 64'(D_icode), 64'h1);
        chk("mp_D_stat", 64'(D_stat), 64'h0);
        chk("mp_bubble_cnt", 64'(bubble_cnt), 64'd1);
        stage_idle();

        // Ret drain: ret passes D, E, M; three stalled, bubbled cycles.
        set_f(4'h9, RNONE, RNONE, 64'd0, 64'd40, 3'd1);
        tick();
        set_f(4'h3, RNONE, 4'h5, 64'd99, 64'd50, 3'd1);
        #1;
        chk("ret1_F_stall", 64'(F_stall), 64'h1);
        tick();
        E_icode = 4'h9;
        #1;
        chk("ret2_D_icode", 64'(D_icode), 64'h1);
        chk("ret2_F_stall", 64'(F_stall), 64'h1);
        tick();
        E_icode = 4'h1; M_icode = 4'h9;
        #1;
        chk("ret3_D_icode", 64'(D_icode), 64'h1);
        chk("ret3_F_stall", 64'(F_stall), 64'h1);
        tick();
        M_icode = 4'h1;
        #1;
        chk("ret4_F_stall", 64'(F_stall), 64'h0);
        tick();
        chk("ret_resume_icode", 64'(D_icode), 64'h3);
        chk("ret_resume_valC", D_valC, 64'd99);
        chk("ret_stall_cnt", 64'(stall_cnt), 64'd4);
        chk("ret_bubble_cnt", 64'(bubble_cnt), 64'd4);

        // Ret in D while a popq to %rsp sits in E: stall first, then bubble.
        set_f(4'h9, RNONE, RNONE, 64'd0, 64'd60, 3'd1);
        tick();
        E_icode = 4'hB; E_dstM = RRSP;
        #1;
        chk("rlu_E_bubble", 64'(E_bubble), 64'h1);
        tick();
        chk("rlu_D_icode_held", 64'(D_icode), 64'h9);
        chk("rlu_bubble_cnt", 64'(bubble_cnt), 64'd4);
        stage_idle();
        tick();
        chk("rlu_D_bubbled", 64'(D_icode), 64'h1);
        chk("rlu_stall_cnt", 64'(stall_cnt), 64'd6);
        chk("rlu_bubble_cnt2", 64'(bubble_cnt), 64'd5);

        // Mispredict coinciding with ret in D.
        set_f(4'h9, RNONE, RNONE, 64'd0, 64'd70, 3'd1);
        tick();
        E_icode = 4'h7; e_Cnd = 1'b0;
        tick();
        chk("mpr_D_icode", 64'(D_icode), 64'h1);
        stage_idle();
        set_f(4'h2, 4'h3, 4'h6, 64'd0, 64'd80, 3'd1);
        tick();
        tick();
        chk("rr_d_srcA", 64'(d_srcA), 64'h3);
        chk("rr_d_srcB", 64'(d_srcB), 64'hF);

        // Saturation: hold a load/use for 2^CNT_W+5 edges.
        set_f(4'h6, 4'h1, 4'h2, 64'd0, 64'd90, 3'd1);
        tick();
        E_icode = 4'h5; E_dstM = 4'h2;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
        chk("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);
        chk("sat_D_icode", 64'(D_icode), 64'h6);
        stage_idle();
        tick();

        // Asynchronous reset in the middle of a stall.
        E_icode = 4'h5; E_dstM = 4'h2;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_D_icode", 64'(D_icode), 64'h1);
        chk("arst_stall_cnt", 64'(stall_cnt), 64'h0);
        stage_idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
